// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// ---------------------------------------------------------------------------
// UART receiver for the board-side serial input. Deframes 8N1 characters
// (8E1 when UART_RX_PARITY_EN is defined) using 16x oversampling derived from
// the system clock, and hands each byte to the generator command path.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : even parity bit between bit 7 and the stop bit.
//   undefined : plain 8N1, no parity state or logic.
//
// Parameters:
//   clock_freq : system clock frequency in Hz
//   baud       : line rate in bit/s
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   rx        in   raw serial line, idle high, asynchronous to clock
//   data      out  received byte, LSB = first data bit
//   valid     out  data holds an unconsumed byte
//   ready     in   consumer accepts data when valid & ready
//   frame_err out  one-cycle pulse: bad stop bit (or bad parity)
//   overrun   out  one-cycle pulse: completed byte dropped, valid was held
//   busy      out  receiver is inside a frame (any state but IDLE)
//   fsm_state out  current FSM state encoding, for observation only
//
// Handshake: valid/ready. A byte transfers on every clock edge where
// valid & ready are both 1. While valid is 1, data is held stable; valid
// drops after a transfer unless a new byte completes on that same edge.
// ready has no effect while valid is 0 and may be tied high.
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int clock_freq = 50000000,
  parameter int baud       = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] fsm_state
);

  // Clocks per oversampling tick, rounded to nearest.
  localparam int DIVISOR = (clock_freq + 8 * baud) / (16 * baud);
  localparam int TW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIVISOR - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY    = 3'd5
`endif
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            rx_m;
  logic            rx_s;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [3:0]      sample_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  // Control strobes from the FSM to the datapath.
  logic            cnt_clr;
  logic            shift_en;
  logic            complete;
  logic            ferr_set;
`ifdef UART_RX_PARITY_EN
  logic            par_capture;
  logic            par_bad;
`endif

  assign busy      = (state != IDLE);
  assign fsm_state = state;
  assign tick      = (state != IDLE) && (tick_cnt == TICK_LAST);

  // Two-flop synchronizer; everything downstream looks only at rx_s.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    complete   = 1'b0;
    ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_capture = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_clr    = 1'b1;
        end
      end
      START: begin
        // Mid start bit: a high line here was only a glitch.
        if (tick && sample_cnt == 4'd7) begin
          cnt_clr    = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && sample_cnt == 4'd15) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && sample_cnt == 4'd15) begin
          par_capture = 1'b1;
          state_next  = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && sample_cnt == 4'd15) begin
          if (!rx_s) begin
            // Stop low (break or framing error): one pulse, then wait for idle.
            ferr_set   = 1'b1;
            state_next = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            ferr_set   = 1'b1;
            state_next = IDLE;
`endif
          end else begin
            complete   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Tick divider and per-bit tick counter. Both sit at zero in IDLE, so
  // entering START always begins a fresh bit period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt   <= '0;
      sample_cnt <= 4'd0;
      bit_idx    <= 3'd0;
    end else begin
      if (state == IDLE || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (state == IDLE || cnt_clr) begin
        sample_cnt <= 4'd0;
      end else if (tick) begin
        sample_cnt <= sample_cnt + 4'd1;
      end

      if (cnt_clr) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Shift register, LSB first: after eight shifts bit 0 sits at shreg[0].
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg <= 8'h00;
    end else if (shift_en) begin
      shreg <= {rx_s, shreg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_bad <= 1'b0;
    end else if (par_capture) begin
      par_bad <= ^{shreg, rx_s};
    end
  end
`endif

  // Output holding register and handshake. A completing byte loads if the
  // slot is free or is being emptied on this same edge; otherwise it is
  // dropped and overrun pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= 1'b0;
      if (complete) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer
// Self-checking bench for uart_rx_deframer at 16 clocks per bit.
// Stimulus is driven 1 time unit after each rising edge; the monitor samples
// on the falling edge. Expected bytes and flag counts come from a frame-level
// model updated when each frame is issued.
module tb_uart_rx_deframer;

  localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] fsm_state;

  uart_rx_deframer #(
    .clock_freq(1600000),
    .baud      (100000)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int  n_cmp     = 0;
  int  n_fail    = 0;
  int  ferr_seen = 0;
  int  ovr_seen  = 0;
  int  ferr_exp  = 0;
  int  ovr_exp   = 0;
  bit  model_holding = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_rst   = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clock) begin
    if (reset) begin
      if (frame_err) ferr_seen++;
      if (overrun)   ovr_seen++;
      // Held byte must not move or vanish without a transfer.
      if (prev_rst && prev_valid && !prev_ready)
        check("hold_stable", {23'd0, valid, data}, {23'd0, 1'b1, prev_data});
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("data", {24'd0, data}, {24'd0, e});
        end
      end
    end
    prev_valid = valid;
    prev_ready = ready;
    prev_data  = data;
    prev_rst   = reset;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    step(BIT_CLKS);
  endtask

  task automatic set_ready(input logic v);
    ready = v;
    if (v) model_holding = 1'b0;
  endtask

  // Frame-level reference: a good frame either lands in the queue or is an
  // overrun if an unconsumed byte is still held and ready is low.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
    bit bad;
    bad = !stop_ok || (PAR_EN && par_flip);
    if (bad) begin
      ferr_exp++;
    end else if (model_holding && !ready) begin
      ovr_exp++;
    end else begin
      exp_q.push_back(b);
      model_holding = !ready;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit((^b) ^ par_flip);
    drive_bit(stop_ok);
    if (!stop_ok) drive_bit(1'b1);
    rx = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_err_count"}, ferr_seen, ferr_exp);
    check({tag, "_overrun_count"}, ovr_seen, ovr_exp);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      step(1);
      t++;
    end
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int vcnt;
    int bcnt;
    int n;

    // Reset and reset-state checks.
    reset = 1'b0;
    step(3);
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_busy", busy, 0);
    check("reset_flags", {frame_err, overrun}, 0);
    reset = 1'b1;
    step(5);

    // 1. 0xA5, ready held high: latency and single-cycle valid.
    set_ready(1'b1);
    lat  = -1;
    vcnt = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        n = 0;
        repeat (200 + (PAR_EN ? 16 : 0)) begin
          @(posedge clock);
          n++;
          @(negedge clock);
          if (valid) begin
            if (lat < 0) lat = n;
            vcnt++;
          end
        end
      end
    join
    check_range("t1_latency", lat, 154 + (PAR_EN ? 16 : 0), 156 + (PAR_EN ? 16 : 0));
    check("t1_valid_cycles", vcnt, 1);
    check_flags("t1");
    wait_drain("t1");

    // 2. Short low glitch on an idle line.
    vcnt = 0;
    bcnt = 0;
    fork
      begin
        rx = 1'b0;
        step(4);
        rx = 1'b1;
      end
      begin
        repeat (40) begin
          @(negedge clock);
          if (valid) vcnt++;
          if (busy) bcnt++;
        end
      end
    join
    step(2);
    check("t2_valid_cycles", vcnt, 0);
    check_range("t2_busy_cycles", bcnt, 1, 12);
    check("t2_idle_after", busy, 0);
    check_flags("t2");

    // 3. Framing error, then a clean frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    step(5);
    send_frame(8'h5A, 1'b1, 1'b0);
    step(5);
    check_flags("t3");
    wait_drain("t3");

    // 4. Overrun with ready low on back-to-back frames.
    set_ready(1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    step(20);
    check("t4_held", {valid, data}, {1'b1, 8'h11});
    check_flags("t4");
    set_ready(1'b1);
    step(3);
    check("t4_valid_after", valid, 0);
    wait_drain("t4");

    // 5. Reset mid-frame during data bit 4 of 0xFF.
    rx = 1'b0;
    step(BIT_CLKS);
    rx = 1'b1;
    step(4 * BIT_CLKS + 8);
    reset = 1'b0;
    step(3);
    check("t5_busy_in_reset", busy, 0);
    reset = 1'b1;
    step(20);
    send_frame(8'h80, 1'b1, 1'b0);
    step(5);
    check_flags("t5");
    wait_drain("t5");

    // 6. Parity (only in the parity build).
    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b1);
      step(5);
      send_frame(8'h07, 1'b1, 1'b0);
      step(5);
      send_frame(8'hC3, 1'b0, 1'b1);
      step(5);
      check_flags("t6");
      wait_drain("t6");
    end

    // Randomized traffic against the frame-level model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      bit stop_ok;
      bit pflip;
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
      pflip   = PAR_EN && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) set_ready(~ready);
      send_frame(b, stop_ok, pflip);
      if ($urandom_range(0, 3) != 0) step($urandom_range(1, 30));
    end
    step(5);
    set_ready(1'b1);
    step(5);
    check_flags("rand");
    wait_drain("rand");
    check("rand_valid_end", valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
